mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences decoded load/store ops (mem_ren/mem_wen/rw_type from instruction decode) onto a single-outstanding
//  req/ack data bus. Stalls the core while an access is in flight; formats byte lanes, write strobes and
//  sign/zero-extended load data. Sits between decode/ALU (address = ALU result) and the data memory bus.
// PARAMETERS
//  TIMEOUT  16  cycles to wait for bus_ack before aborting with err (counter width = $clog2(TIMEOUT+1))
// PORTS
//  clk        in   1   core clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   op valid this cycle (sampled only in IDLE)
//  mem_ren    in   1   load op
//  mem_wen    in   1   store op
//  rw_type    in   4   {u,w,h,b} one-hot size + unsigned flag
//  addr       in   32  byte address
//  wdata      in   32  store data (rs2), LSB-aligned
//  stall      out  1   hold pipeline
//  done       out  1   1-cycle pulse: access completed
//  err        out  1   1-cycle pulse: access aborted
//  rdata      out  32  extended load data, valid when done (load)
//  bus_req    out  1   request, held until bus_ack
//  bus_we     out  1   1=write
//  bus_addr   out  32  word address {addr[31:2],2'b00}
//  bus_wstrb  out  4   byte strobes (0 on reads)
//  bus_wdata  out  32  lane-replicated store data
//  bus_ack    in   1   bus accepted/completed access this cycle
//  bus_rdata  in   32  read word, valid with bus_ack
// BEHAVIOUR
//  - FSM IDLE -> REQ -> RESP -> IDLE; ERR state = 1-cycle abort, then IDLE.
//  - Reset: state IDLE; bus_req/bus_we/done/err/stall 0; bus_addr/bus_wstrb/bus_wdata/rdata 0; counter 0.
//  - IDLE: start & (mem_ren^mem_wen) & legal -> capture addr/size/we/wdata, go REQ. start with neither
//    mem_ren nor mem_wen: ignored. start with both set, or w/h/b not exactly one-hot, or u with w: ERR.
//  - REQ: bus_req=1, bus_* registered, stable until ack. bus_ack -> latch bus_rdata, go RESP. Counter
//    increments each REQ cycle; reaching TIMEOUT without ack -> ERR, bus_req drops next cycle.
//  - RESP: done=1, rdata valid; -> IDLE. ERR: err=1; -> IDLE. New start accepted next IDLE cycle.
//  - Latency: start@T0 -> bus_req@T1; ack@Tn -> done@Tn+1. Minimum 3 cycles start-to-done (ack@T1).
//  - stall = (IDLE & start & (mem_ren|mem_wen)) | REQ; low in RESP/ERR so the pipeline advances.
//  - Strobes: b -> 4'b0001<<addr[1:0]; h -> 4'b0011<<addr[1:0]; w -> 4'b1111.
//  - wdata: b -> {4{wdata[7:0]}}; h -> {2{wdata[15:0]}}; w -> wdata.
//  - rdata: word >> (8*addr[1:0]), then b/h sign-extend (u=0) or zero-extend (u=1); w passes through.
//  - Reset mid-access: bus_req drops asynchronously; no done/err pulse; latched op discarded.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: h with addr[0]=1 or w with addr[1:0]!=0 -> ERR from IDLE, no bus cycle.
//  Not defined: low address bits forced to alignment (h clears addr[0], w clears addr[1:0]); never errors
//  on alignment.
// STRUCTURE
//  Package rv_pkg: FSM state enum {IDLE,REQ,RESP,ERR}; RW_U/RW_W/RW_H/RW_B bit indices of rw_type;
//  bus strobe constants. Sub-module mem_lane_fmt (combinational): strobe gen, wdata replication,
//  rdata shift+extend; instanced once, driven by captured size/offset.
// TESTING
//  1 sw addr=0x100 wdata=0xDEADBEEF, ack@T2 -> bus_wstrb=1111, bus_addr=0x100, done@T3, stall T0..T2.
//  2 sb addr=0x103 wdata=0x000000A5 -> bus_wstrb=1000, bus_wdata=0xA5A5A5A5.
//  3 lb addr=0x102, bus_rdata=0x0080_0000 -> rdata=0xFFFFFF80; lbu same -> rdata=0x00000080.
//  4 lh addr=0x102, bus_rdata=0x8001_1234 -> rdata=0xFFFF8001; lhu -> 0x00008001.
//  5 no ack for TIMEOUT=16 cycles -> err pulse, bus_req 0 next cycle, no done; next start serviced.
//  6 lw addr=0x101: trap build -> err, no bus_req; non-trap build -> bus_addr=0x100, done.
//  7 rst asserted while bus_req=1 -> bus_req 0 same cycle, no done/err after release.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the load/store access controller.
//   state_e       : access FSM states
//   RW_*          : bit positions inside rw_type ({u,w,h,b})
//   STRB_*        : byte-strobe base patterns (shifted by byte offset for b/h)
//   size_onehot() : true when the w/h/b field selects exactly one size
package rv_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StResp = 2'd2,
      StErr  = 2'd3
   } state_e;

   localparam int unsigned RW_B = 0;
   localparam int unsigned RW_H = 1;
   localparam int unsigned RW_W = 2;
   localparam int unsigned RW_U = 3;

   localparam logic [3:0] STRB_NONE = 4'b0000;
   localparam logic [3:0] STRB_B    = 4'b0001;
   localparam logic [3:0] STRB_H    = 4'b0011;
   localparam logic [3:0] STRB_W    = 4'b1111;

   function automatic logic size_onehot(input logic [2:0] sz);
      return (sz == 3'b001) || (sz == 3'b010) || (sz == 3'b100);
   endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatter for the data bus.
//   size_i   : one-hot {w,h,b}
//   uns_i    : 1 = zero-extend loads, 0 = sign-extend
//   off_i    : byte offset inside the word (already aligned for h/w)
//   wdata_i  : LSB-aligned store data
//   rword_i  : raw bus read word
//   wstrb_o  : byte strobes for a store of this size/offset
//   wdata_o  : store data replicated across all lanes of its size
//   rdata_o  : read word shifted down to the offset and extended
module mem_lane_fmt
   import rv_pkg::*;
(
   input  logic [2:0]  size_i,
   input  logic        uns_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rword_i >> {off_i, 3'b000};
      wstrb_o = STRB_NONE;
      wdata_o = wdata_i;
      rdata_o = shifted;
      if (size_i[RW_B]) begin
         wstrb_o = STRB_B << off_i;
         wdata_o = {4{wdata_i[7:0]}};
         rdata_o = uns_i ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end else if (size_i[RW_H]) begin
         wstrb_o = STRB_H << off_i;
         wdata_o = {2{wdata_i[15:0]}};
         rdata_o = uns_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end else if (size_i[RW_W]) begin
         wstrb_o = STRB_W;
         wdata_o = wdata_i;
         rdata_o = shifted;
      end
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: turns one decoded memory op into a single-outstanding
// req/ack bus transaction, stalling the core while the access is in flight.
// Build option: define MEM_MISALIGN_TRAP_EN to abort misaligned h/w accesses
// with err; otherwise the low address bits are forced to alignment.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, mem_ren, mem_wen  : op valid and load/store select
//   rw_type                  : {u,w,h,b} size and unsigned flag
//   addr, wdata              : byte address and LSB-aligned store data
//   stall, done, err, rdata  : core-side status and extended load data
//   bus_req .. bus_wdata     : registered bus request, held until bus_ack
//   bus_ack, bus_rdata       : bus completion and read word
module mem_access_ctrl
   import rv_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [3:0]  rw_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [1:0]      off_q, off_d;
   logic            bus_req_q, bus_req_d;
   logic            bus_we_q, bus_we_d;
   logic [31:0]     bus_addr_q, bus_addr_d;
   logic [3:0]      bus_wstrb_q, bus_wstrb_d;
   logic [31:0]     bus_wdata_q, bus_wdata_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic [31:0]     rdata_q, rdata_d;

   logic        is_idle;
   logic        op_one, op_both, size_ok, misalign, accept, reject;
   logic [1:0]  in_off;
   logic [2:0]  fmt_size;
   logic        fmt_uns;
   logic [1:0]  fmt_off;
   logic [3:0]  fmt_wstrb;
   logic [31:0] fmt_wdata, fmt_rdata;

   assign is_idle = (state_q == StIdle);

   // Decode of the incoming op; only meaningful while idle.
   always_comb begin
      op_one  = start & (mem_ren ^ mem_wen);
      op_both = start & mem_ren & mem_wen;
      size_ok = size_onehot(rw_type[2:0]) & ~(rw_type[RW_U] & rw_type[RW_W]);
`ifdef MEM_MISALIGN_TRAP_EN
      misalign = (rw_type[RW_H] & addr[0]) | (rw_type[RW_W] & (addr[1:0] != 2'b00));
      in_off   = addr[1:0];
`else
      misalign = 1'b0;
      // Force natural alignment instead of trapping.
      if (rw_type[RW_W]) begin
         in_off = 2'b00;
      end else if (rw_type[RW_H]) begin
         in_off = {addr[1], 1'b0};
      end else begin
         in_off = addr[1:0];
      end
`endif
      accept = op_one & size_ok & ~misalign;
      reject = op_both | (op_one & (~size_ok | misalign));
   end

   // One formatter: fed by the live op while idle (store lanes are registered
   // at capture), by the captured size/offset during REQ (load extension).
   always_comb begin
      fmt_size = is_idle ? rw_type[2:0]    : size_q;
      fmt_uns  = is_idle ? rw_type[RW_U]   : uns_q;
      fmt_off  = is_idle ? in_off          : off_q;
   end

   mem_lane_fmt u_lane_fmt (
      .size_i  (fmt_size),
      .uns_i   (fmt_uns),
      .off_i   (fmt_off),
      .wdata_i (wdata),
      .rword_i (bus_rdata),
      .wstrb_o (fmt_wstrb),
      .wdata_o (fmt_wdata),
      .rdata_o (fmt_rdata)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      uns_d       = uns_q;
      off_d       = off_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wstrb_d = bus_wstrb_q;
      bus_wdata_d = bus_wdata_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;

      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d     = StReq;
               cnt_d       = '0;
               size_d      = rw_type[2:0];
               uns_d       = rw_type[RW_U];
               off_d       = in_off;
               bus_req_d   = 1'b1;
               bus_we_d    = mem_wen;
               bus_addr_d  = {addr[31:2], 2'b00};
               bus_wstrb_d = mem_wen ? fmt_wstrb : STRB_NONE;
               bus_wdata_d = fmt_wdata;
            end else if (reject) begin
               state_d = StErr;
               err_d   = 1'b1;
            end
         end
         StReq: begin
            if (bus_ack || (cnt_q == CntW'(TIMEOUT - 1))) begin
               state_d     = bus_ack ? StResp : StErr;
               done_d      = bus_ack;
               err_d       = ~bus_ack;
               if (bus_ack && !bus_we_q) begin
                  rdata_d = fmt_rdata;
               end
               cnt_d       = '0;
               bus_req_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_addr_d  = '0;
               bus_wstrb_d = STRB_NONE;
               bus_wdata_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         off_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wstrb_q <= '0;
         bus_wdata_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         off_q       <= off_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wstrb_q <= bus_wstrb_d;
         bus_wdata_q <= bus_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
      end
   end

   // Stall is asserted in the issuing cycle so the core holds before the
   // request is even registered; it drops in RESP/ERR to let the pipe advance.
   assign stall     = (state_q == StReq) | (is_idle & start & (mem_ren | mem_wen));
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wstrb = bus_wstrb_q;
   assign bus_wdata = bus_wdata_q;

endmodule
